// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state, interrupt enables/pending, counters.
// Ports: decode read, execute write, trap load/return, irq lines, status outs.
module csr_file (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        instret_i,
  input  logic        irq_external_i,
  input  logic        irq_timer_i,
  input  logic        irq_software_i,
  input  logic        ie_type_i,
  input  logic        set_cause_i,
  input  logic [3:0]  trap_cause_i,
  input  logic        set_epc_i,
  input  logic [31:0] epc_i,
  input  logic        set_mtval_i,
  input  logic [31:0] mtval_i,
  input  logic        mstatus_ie_clear_i,
  input  logic        mstatus_ie_set_i,
  output logic        mstatus_ie_o,
  output logic        mie_external_o,
  output logic        mie_timer_o,
  output logic        mie_sw_o,
  output logic        mip_external_o,
  output logic        mip_timer_o,
  output logic        mip_sw_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] epc_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [2:0]  mie_q, mie_d;
  logic [2:0]  mip_q, mip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  function automatic logic wr(input logic [11:0] a);
    return we_i && (waddr_i == a);
  endfunction

  // One read mux serves both the live view and the forwarded view.
  function automatic logic [31:0] view(
    input logic [11:0] a,
    input logic        s_mie,
    input logic        s_mpie,
    input logic [2:0]  ie,
    input logic [2:0]  ip,
    input logic [31:0] tvec,
    input logic [31:0] scr,
    input logic [31:0] epc,
    input logic [31:0] cause,
    input logic [31:0] tval,
    input logic [63:0] cyc,
    input logic [63:0] ins
  );
    logic [31:0] r;
    r = '0;
    case (a)
      A_MSTATUS:  r = {19'b0, 2'b11, 3'b0, s_mpie, 3'b0, s_mie, 3'b0};
      A_MISA:     r = 32'h4000_0100;
      A_MIE:      r = {20'b0, ie[2], 3'b0, ie[1], 3'b0, ie[0], 3'b0};
      A_MTVEC:    r = tvec;
      A_MSCRATCH: r = scr;
      A_MEPC:     r = epc;
      A_MCAUSE:   r = cause;
      A_MTVAL:    r = tval;
      A_MIP:      r = {20'b0, ip[2], 3'b0, ip[1], 3'b0, ip[0], 3'b0};
      A_MCYCLE:   r = cyc[31:0];
      A_MCYCLEH:  r = cyc[63:32];
      A_MINSTR:   r = ins[31:0];
      A_MINSTRH:  r = ins[63:32];
      A_MVENDOR:  r = 32'h0;
      A_MHARTID:  r = 32'h0;
      default:    r = 32'h0;
    endcase
    return r;
  endfunction

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mip_d      = {irq_external_i, irq_timer_i, irq_software_i};
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instret_i};

    if (wr(A_MSTATUS)) begin
      st_mie_d  = wdata_i[3];
      st_mpie_d = wdata_i[7];
    end
    // Trap entry beats return; both beat a software write.
    if (mstatus_ie_clear_i) begin
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mstatus_ie_set_i) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end

    if (wr(A_MIE))
      mie_d = {wdata_i[11], wdata_i[7], wdata_i[3]};
    if (wr(A_MTVEC))
      mtvec_d = wdata_i & 32'hFFFF_FFFD;
    if (wr(A_MSCRATCH))
      mscratch_d = wdata_i;

    if (wr(A_MEPC))
      mepc_d = wdata_i & 32'hFFFF_FFFC;
    if (set_epc_i)
      mepc_d = epc_i & 32'hFFFF_FFFC;

    if (wr(A_MCAUSE))
      mcause_d = wdata_i & 32'h8000_000F;
    if (set_cause_i)
      mcause_d = {ie_type_i, 27'b0, trap_cause_i};

    if (wr(A_MTVAL))
      mtval_d = wdata_i;
    if (set_mtval_i)
      mtval_d = mtval_i;

    // A half-write freezes the whole counter for that cycle.
    if (wr(A_MCYCLE))
      mcycle_d = {mcycle_q[63:32], wdata_i};
    else if (wr(A_MCYCLEH))
      mcycle_d = {wdata_i, mcycle_q[31:0]};

    if (wr(A_MINSTR))
      minstret_d = {minstret_q[63:32], wdata_i};
    else if (wr(A_MINSTRH))
      minstret_d = {wdata_i, minstret_q[31:0]};
  end

  always_ff @(posedge clk_i) begin
    if (n_rst_i) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Forwarded reads see the post-write value; mip ignores writes.
  always_comb begin
    if (we_i && (raddr_i == waddr_i))
      rdata_o = view(raddr_i, st_mie_d, st_mpie_d, mie_d, mip_q,
                     mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d,
                     mcycle_d, minstret_d);
    else
      rdata_o = view(raddr_i, st_mie_q, st_mpie_q, mie_q, mip_q,
                     mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q,
                     mcycle_q, minstret_q);
  end

  assign mstatus_ie_o   = st_mie_q;
  assign mie_external_o = mie_q[2];
  assign mie_timer_o    = mie_q[1];
  assign mie_sw_o       = mie_q[0];
  assign mip_external_o = mip_q[2];
  assign mip_timer_o    = mip_q[1];
  assign mip_sw_o       = mip_q[0];
  assign mtvec_o        = mtvec_q;
  assign epc_o          = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: hand-computed vectors for each register,
// trap sequencing, counter carry/wrap, forwarding and reset override.
module tb_csr_file;
  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic [11:0] raddr_i;
  logic [31:0] rdata_o;
  logic        we_i;
  logic [11:0] waddr_i;
  logic [31:0] wdata_i;
  logic        instret_i;
  logic        irq_external_i, irq_timer_i, irq_software_i;
  logic        ie_type_i, set_cause_i;
  logic [3:0]  trap_cause_i;
  logic        set_epc_i;
  logic [31:0] epc_i;
  logic        set_mtval_i;
  logic [31:0] mtval_i;
  logic        mstatus_ie_clear_i, mstatus_ie_set_i;
  logic        mstatus_ie_o;
  logic        mie_external_o, mie_timer_o, mie_sw_o;
  logic        mip_external_o, mip_timer_o, mip_sw_o;
  logic [31:0] mtvec_o, epc_o;

  int checks = 0;
  int errors = 0;

  csr_file dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .instret_i(instret_i),
    .irq_external_i(irq_external_i), .irq_timer_i(irq_timer_i),
    .irq_software_i(irq_software_i),
    .ie_type_i(ie_type_i), .set_cause_i(set_cause_i),
    .trap_cause_i(trap_cause_i),
    .set_epc_i(set_epc_i), .epc_i(epc_i),
    .set_mtval_i(set_mtval_i), .mtval_i(mtval_i),
    .mstatus_ie_clear_i(mstatus_ie_clear_i),
    .mstatus_ie_set_i(mstatus_ie_set_i),
    .mstatus_ie_o(mstatus_ie_o),
    .mie_external_o(mie_external_o), .mie_timer_o(mie_timer_o),
    .mie_sw_o(mie_sw_o),
    .mip_external_o(mip_external_o), .mip_timer_o(mip_timer_o),
    .mip_sw_o(mip_sw_o),
    .mtvec_o(mtvec_o), .epc_o(epc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] a,
                    input logic [31:0] exp);
    raddr_i = a;
    #1;
    check(tag, rdata_o, exp);
  endtask

  task automatic wr1(input logic [11:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  initial begin
    n_rst_i = 1'b1; raddr_i = 12'h340;
    we_i = 1'b1; waddr_i = 12'h340; wdata_i = 32'hDEAD_BEEF;
    instret_i = 0; irq_external_i = 0; irq_timer_i = 0; irq_software_i = 0;
    ie_type_i = 0; set_cause_i = 0; trap_cause_i = 0;
    set_epc_i = 1; epc_i = 32'h1234_5678;
    set_mtval_i = 0; mtval_i = 0;
    mstatus_ie_clear_i = 0; mstatus_ie_set_i = 0;
    tick(); tick();
    we_i = 1'b0; set_epc_i = 1'b0;
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    check("rst_epc_o", epc_o, 32'h0);
    check("rst_outs", {mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o,
                       mip_external_o, mip_timer_o, mip_sw_o}, 32'h0);

    n_rst_i = 1'b0;
    tick();
    rd("mcycle_first", 12'hB00, 32'h1);

    // mstatus mask and forwarding
    we_i = 1; waddr_i = 12'h300; wdata_i = 32'hFFFF_FFFF;
    rd("mstatus_fwd", 12'h300, 32'h0000_1888);
    tick(); we_i = 0;
    rd("mstatus_wr", 12'h300, 32'h0000_1888);
    check("mstatus_ie_o", {31'b0, mstatus_ie_o}, 32'h1);

    wr1(12'h304, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'h0000_0888);
    check("mie_outs", {29'b0, mie_external_o, mie_timer_o, mie_sw_o}, 32'h7);

    // trap entry with cause/epc, then return
    mstatus_ie_clear_i = 1; set_epc_i = 1; epc_i = 32'h0000_0103;
    set_cause_i = 1; ie_type_i = 1; trap_cause_i = 4'hB;
    tick();
    mstatus_ie_clear_i = 0; set_epc_i = 0; set_cause_i = 0;
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_mepc", 12'h341, 32'h0000_0100);
    rd("trap_mcause", 12'h342, 32'h8000_000B);
    check("trap_epc_o", epc_o, 32'h0000_0100);
    mstatus_ie_set_i = 1; tick(); mstatus_ie_set_i = 0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    mstatus_ie_clear_i = 1; mstatus_ie_set_i = 1; tick();
    mstatus_ie_clear_i = 0; mstatus_ie_set_i = 0;
    rd("clr_wins", 12'h300, 32'h0000_1880);

    // write vs trap load and mtvec forwarding
    we_i = 1; waddr_i = 12'h341; wdata_i = 32'h200;
    set_epc_i = 1; epc_i = 32'h400;
    tick(); we_i = 0; set_epc_i = 0;
    rd("epc_trap_wins", 12'h341, 32'h400);
    we_i = 1; waddr_i = 12'h343; wdata_i = 32'h5555;
    set_mtval_i = 1; mtval_i = 32'h1234;
    tick(); we_i = 0; set_mtval_i = 0;
    rd("mtval_trap_wins", 12'h343, 32'h1234);
    we_i = 1; waddr_i = 12'h305; wdata_i = 32'h8000_0003;
    rd("mtvec_fwd", 12'h305, 32'h8000_0001);
    tick(); we_i = 0;
    check("mtvec_o", mtvec_o, 32'h8000_0001);
    wr1(12'h342, 32'hFFFF_FFFF);
    rd("mcause_mask", 12'h342, 32'h8000_000F);

    wr1(12'h301, 32'h0);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("unmapped", 12'h7C0, 32'h0);
    rd("mhartid", 12'hF14, 32'h0);

    // mcycle carry
    wr1(12'hB80, 32'h0);
    wr1(12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcycle_carry_lo", 12'hB00, 32'h0);
    rd("mcycle_carry_hi", 12'hB80, 32'h1);

    // mcycle wrap
    wr1(12'hB80, 32'hFFFF_FFFF);
    wr1(12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd("mcycle_wrap_hi", 12'hB80, 32'h0);

    // minstret carry and write override
    wr1(12'hB82, 32'h0);
    wr1(12'hB02, 32'hFFFF_FFFF);
    rd("minstret_hold", 12'hB02, 32'hFFFF_FFFF);
    instret_i = 1; tick(); instret_i = 0;
    rd("minstret_lo", 12'hB02, 32'h0);
    rd("minstret_hi", 12'hB82, 32'h1);
    instret_i = 1; we_i = 1; waddr_i = 12'hB02; wdata_i = 32'h5;
    tick(); instret_i = 0; we_i = 0;
    rd("minstret_wr_wins", 12'hB02, 32'h5);

    // mip latency and write-ignore
    irq_timer_i = 1;
    #1;
    check("mip_before", {31'b0, mip_timer_o}, 32'h0);
    tick(); irq_timer_i = 0;
    check("mip_set", {31'b0, mip_timer_o}, 32'h1);
    tick();
    check("mip_clear", {31'b0, mip_timer_o}, 32'h0);
    wr1(12'h344, 32'hFFFF_FFFF);
    rd("mip_wr_ignored", 12'h344, 32'h0);

    // reset in the middle of a write
    wr1(12'h340, 32'h0000_AAAA);
    rd("mscratch_wr", 12'h340, 32'h0000_AAAA);
    n_rst_i = 1; we_i = 1; waddr_i = 12'h340; wdata_i = 32'h5555;
    tick();
    we_i = 0; n_rst_i = 0;
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    rd("rst2_mcycle", 12'hB00, 32'h0);
    check("rst2_mtvec_o", mtvec_o, 32'h0);
    check("rst2_epc_o", epc_o, 32'h0);
    check("rst2_outs", {mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o,
                        mip_external_o, mip_timer_o, mip_sw_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL provide ports, clock and reset first:
clk_i  in  1  single clock, all state on rising edge
n_rst_i  in  1  synchronous reset, active-high (1 = reset)
raddr_i  in  12  CSR read address from decode
rdata_o  out  32  CSR read data, combinational
we_i  in  1  CSR write enable from execute
waddr_i  in  12  CSR write address
wdata_i  in  32  CSR write data (already RW/RS/RC-resolved)
instret_i  in  1  one pulse per retired instruction
irq_external_i / irq_timer_i / irq_software_i  in  1 each  raw interrupt lines
ie_type_i  in  1  1 = interrupt, 0 = exception
set_cause_i  in  1  load mcause
trap_cause_i  in  4  cause code
set_epc_i  in  1  load mepc
epc_i  in  32  trap PC
set_mtval_i  in  1  load mtval
mtval_i  in  32  trap value
mstatus_ie_clear_i  in  1  trap entry
mstatus_ie_set_i  in  1  trap return
mstatus_ie_o  out  1  mstatus.MIE
mie_external_o / mie_timer_o / mie_sw_o  out  1 each  mie[11]/[7]/[3]
mip_external_o / mip_timer_o / mip_sw_o  out  1 each  mip[11]/[7]/[3]
mtvec_o  out  32  mtvec
epc_o  out  32  mepc

Function
REQ-002 Address map SHALL be: 0x300 mstatus, 0x301 misa, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip, 0xB00 mcycle, 0xB80 mcycleh, 0xB02 minstret, 0xB82 minstreth, 0xF11 mvendorid, 0xF14 mhartid.
REQ-003 Unmapped read SHALL return 0; unmapped write SHALL be ignored.
REQ-004 Read-only constants: misa = 0x40000100 (RV32I), mvendorid = 0, mhartid = 0; writes ignored.
REQ-005 mstatus: only MIE (bit 3) and MPIE (bit 7) writable; MPP (bits 12:11) reads 2'b11; other bits read 0.
REQ-006 mie: only bits 11, 7, 3 writable; others read 0.
REQ-007 mtvec: bits 31:2 writable; bit 0 writable (mode); bit 1 reads 0.
REQ-008 mepc: bits 1:0 forced to 0 on both CSR write and set_epc_i load.
REQ-009 mcause = {ie_type, 27'b0, cause[3:0]}; software write stores bit 31 and bits 3:0 only.
REQ-010 mip: bits 11/7/3 SHALL be registered copies of irq_external_i/irq_timer_i/irq_software_i (one-cycle latency); software writes ignored.
REQ-011 mcycle (64-bit) SHALL increment by 1 every cycle; a write to 0xB00/0xB80 replaces that 32-bit half with wdata_i that cycle (no increment that cycle), other half unchanged.
REQ-012 minstret (64-bit) SHALL increment on instret_i with carry into high half; write behaves as REQ-011 and overrides instret_i that cycle.
REQ-013 Counters SHALL wrap 0xFFFFFFFF_FFFFFFFF -> 0.
REQ-014 Trap entry (mstatus_ie_clear_i): MPIE <= MIE, MIE <= 0.
REQ-015 Trap return (mstatus_ie_set_i): MIE <= MPIE, MPIE <= 1.
REQ-016 clear and set asserted together: clear SHALL win.
REQ-017 Same-cycle CSR write and trap load to the same register (mstatus, mepc, mcause, mtval): trap load SHALL win.
REQ-018 set_cause_i, set_epc_i, set_mtval_i are independent; each loads only its register.
REQ-019 Read forwarding: we_i=1 and raddr_i==waddr_i SHALL return the value the register will hold after the write (masks of REQ-005..009 applied); counters return written half.
REQ-020 Outputs mstatus_ie_o, mie_*_o, mip_*_o, mtvec_o, epc_o SHALL reflect register state (no forwarding).

Reset
REQ-021 With n_rst_i=1 at a clock edge all state clears: mstatus MIE=MPIE=0, mie=0, mip=0, mtvec=0, mscratch=0, mepc=0, mcause=0, mtval=0, mcycle=0, minstret=0; outputs 0 the following cycle.
REQ-022 Reset SHALL override every write/trap input in the same cycle; mcycle reads 1 the first cycle after reset release +1 edge.

Verification
REQ-023 Write 0x300 = 0xFFFFFFFF, read 0x300 -> 0x00001888; mstatus_ie_o = 1.
REQ-024 MIE=1, pulse mstatus_ie_clear_i + set_epc_i(epc 0x00000103) + set_cause_i(ie_type 1, cause 0xB) -> mstatus 0x1880, mepc 0x00000100, mcause 0x8000000B; then mstatus_ie_set_i -> mstatus 0x1888.
REQ-025 Write mcycle low 0xFFFFFFFF with mcycleh 0 -> next cycle low 0, mcycleh 1.
REQ-026 Same cycle we_i to 0x341 (0x200) and set_epc_i (0x400) -> mepc 0x400; same-cycle read 0x305 after writing 0x305 = 0x80000003 -> rdata_o 0x80000001.
REQ-027 irq_timer_i high for 1 cycle -> mip_timer_o high exactly one cycle later for one cycle; write 0x344 = 0xFFFFFFFF -> no change.
REQ-028 Assert n_rst_i mid-operation with we_i to mscratch -> mscratch 0, all outputs 0.
